// File: rtl/stl_packet_framer_if.sv
// Purpose: byte and packet handshake bundle between the SerialTL framer and its neighbours.
// Signals:
//   in_valid/in_ready/in_data                  request bytes from the UART handler
//   pkt_valid/pkt_ready/pkt_data               assembled request packet to the TL bridge
//   rsp_pkt_valid/rsp_pkt_ready/rsp_pkt_data   response packet from the TL bridge
//   out_valid/out_ready/out_data               response bytes to the UART handler
// Modports: master = environment side, slave = framer side.
interface stl_packet_framer_if #(
  parameter int unsigned PACKET_BYTES = 16
) ();
  logic                        in_valid;
  logic                        in_ready;
  logic [7:0]                  in_data;
  logic                        pkt_valid;
  logic                        pkt_ready;
  logic [8*PACKET_BYTES-1:0]   pkt_data;
  logic                        rsp_pkt_valid;
  logic                        rsp_pkt_ready;
  logic [8*PACKET_BYTES-1:0]   rsp_pkt_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [7:0]                  out_data;

  modport master (
    output in_valid, in_data, pkt_ready, rsp_pkt_valid, rsp_pkt_data, out_ready,
    input  in_ready, pkt_valid, pkt_data, rsp_pkt_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, pkt_ready, rsp_pkt_valid, rsp_pkt_data, out_ready,
    output in_ready, pkt_valid, pkt_data, rsp_pkt_ready, out_valid, out_data
  );
endinterface

// File: rtl/stl_packet_framer.sv
// Purpose: byte<->packet framer for the SerialTL path. Collects PACKET_BYTES request
//   bytes into one packet (dropping a stalled partial packet after TIMEOUT_CYCLES idle
//   cycles), buffers RSP_DEPTH response packets and serialises them back as bytes.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   link (slave)       request byte in, request packet out, response packet in,
//                      response byte out (see stl_packet_framer_if)
//   timeout_drop       one-cycle pulse when a partial request is discarded
//   debug_byte_count   request bytes collected so far
//   debug_state        RX state: 0 IDLE, 1 COLLECT, 2 HOLD
// Optional feature macro: STL_FRAMER_STATS_EN adds STAT_W-bit saturating counters
//   stat_rx_pkts, stat_tx_pkts and stat_drops.
module stl_packet_framer #(
  parameter int unsigned PACKET_BYTES   = 16,
  parameter int unsigned RSP_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
`ifdef STL_FRAMER_STATS_EN
  ,
  parameter int unsigned STAT_W         = 16
`endif
) (
  input  logic                                clk,
  input  logic                                reset_n,
  stl_packet_framer_if.slave                  link,
  output logic                                timeout_drop,
  output logic [$clog2(PACKET_BYTES+1)-1:0]   debug_byte_count,
  output logic [1:0]                          debug_state
`ifdef STL_FRAMER_STATS_EN
  ,
  output logic [STAT_W-1:0]                   stat_rx_pkts,
  output logic [STAT_W-1:0]                   stat_tx_pkts,
  output logic [STAT_W-1:0]                   stat_drops
`endif
);

  localparam int unsigned PKT_W  = 8 * PACKET_BYTES;
  localparam int unsigned CNT_W  = $clog2(PACKET_BYTES + 1);
  localparam int unsigned IDX_W  = $clog2(PACKET_BYTES);
  localparam int unsigned PTR_W  = $clog2(RSP_DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_COLLECT = 2'd1,
    RX_HOLD    = 2'd2
  } rx_state_t;

  // ---------------------------------------------------------------- RX path
  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] byte_cnt, cnt_nxt;
  logic [TO_W-1:0]  idle_cnt, idle_nxt;
  logic             drop_c;
  logic [PKT_W-1:0] pkt_buf;
  logic             in_acc;
  logic             pkt_hs;

  assign in_acc = link.in_valid && link.in_ready;
  assign pkt_hs = link.pkt_valid && link.pkt_ready;

  // RX next-state: collect bytes, hold the packet, drop on inter-byte timeout
  always_comb begin
    state_nxt = state;
    cnt_nxt   = byte_cnt;
    idle_nxt  = idle_cnt;
    drop_c    = 1'b0;
    case (state)
      RX_IDLE: begin
        if (in_acc) begin
          state_nxt = RX_COLLECT;
          cnt_nxt   = CNT_W'(1);
          idle_nxt  = '0;
        end
      end
      RX_COLLECT: begin
        if (in_acc) begin
          idle_nxt = '0;
          if (byte_cnt == CNT_W'(PACKET_BYTES - 1)) begin
            state_nxt = RX_HOLD;
            cnt_nxt   = CNT_W'(PACKET_BYTES);
          end else begin
            cnt_nxt = byte_cnt + CNT_W'(1);
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          // An accepted byte takes priority, so the drop only fires on an idle cycle
          if (idle_cnt == TO_W'(TO_LIM)) begin
            state_nxt = RX_IDLE;
            cnt_nxt   = '0;
            idle_nxt  = '0;
            drop_c    = 1'b1;
          end else begin
            idle_nxt = idle_cnt + TO_W'(1);
          end
        end
      end
      RX_HOLD: begin
        if (pkt_hs) begin
          state_nxt = RX_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RX_IDLE;
        cnt_nxt   = '0;
        idle_nxt  = '0;
      end
    endcase
  end

  // RX state register; handshake outputs are registered copies of the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RX_IDLE;
      byte_cnt       <= '0;
      idle_cnt       <= '0;
      link.in_ready  <= 1'b0;
      link.pkt_valid <= 1'b0;
      timeout_drop   <= 1'b0;
    end else begin
      state          <= state_nxt;
      byte_cnt       <= cnt_nxt;
      idle_cnt       <= idle_nxt;
      link.in_ready  <= (state_nxt != RX_HOLD);
      link.pkt_valid <= (state_nxt == RX_HOLD);
      timeout_drop   <= drop_c;
    end
  end

  // Shift bytes in from the top; after PACKET_BYTES accepts byte 0 sits at [7:0]
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_buf <= '0;
    end else if (in_acc) begin
      pkt_buf <= {link.in_data, pkt_buf[PKT_W-1:8]};
    end
  end

  assign link.pkt_data    = pkt_buf;
  assign debug_byte_count = byte_cnt;
  assign debug_state      = state;

  // ---------------------------------------------------------------- response FIFO
  logic [PKT_W-1:0] mem [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ, occ_nxt;
  logic             push, pop;
  logic [PKT_W-1:0] tx_buf;
  logic [IDX_W-1:0] tx_idx;
  logic             tx_last;

  assign push    = link.rsp_pkt_valid && link.rsp_pkt_ready;
  assign pop     = !link.out_valid && (occ != '0);
  assign tx_last = link.out_valid && link.out_ready && (tx_idx == IDX_W'(PACKET_BYTES - 1));

  // Occupancy after this cycle's push/pop
  always_comb begin
    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = occ + OCC_W'(1);
      2'b01:   occ_nxt = occ - OCC_W'(1);
      default: occ_nxt = occ;
    endcase
  end

  // Pointers wrap naturally because RSP_DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      occ                <= '0;
      link.rsp_pkt_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      occ                <= occ_nxt;
      link.rsp_pkt_ready <= (occ_nxt != OCC_W'(RSP_DEPTH));
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= link.rsp_pkt_data;
  end

  // ---------------------------------------------------------------- TX serializer
  // out_valid doubles as the busy flag; loading only when idle gives one bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_buf         <= '0;
      tx_idx         <= '0;
      link.out_valid <= 1'b0;
    end else if (pop) begin
      tx_buf         <= mem[rd_ptr];
      tx_idx         <= '0;
      link.out_valid <= 1'b1;
    end else if (link.out_valid && link.out_ready) begin
      if (tx_last) begin
        link.out_valid <= 1'b0;
      end else begin
        tx_idx <= tx_idx + IDX_W'(1);
        tx_buf <= {8'h00, tx_buf[PKT_W-1:8]};
      end
    end
  end

  assign link.out_data = tx_buf[7:0];

`ifdef STL_FRAMER_STATS_EN
  // ---------------------------------------------------------------- statistics
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_rx_pkts <= '0;
      stat_tx_pkts <= '0;
      stat_drops   <= '0;
    end else begin
      if (pkt_hs && (stat_rx_pkts != '1)) stat_rx_pkts <= stat_rx_pkts + STAT_W'(1);
      if (tx_last && (stat_tx_pkts != '1)) stat_tx_pkts <= stat_tx_pkts + STAT_W'(1);
      if (drop_c && (stat_drops != '1)) stat_drops <= stat_drops + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_stl_packet_framer.sv
// Purpose: directed self-checking bench for stl_packet_framer (PACKET_BYTES=16,
//   RSP_DEPTH=4, TIMEOUT_CYCLES=50). Inputs change and outputs are sampled on the
//   falling clock edge; the rising edge is the active edge.
module tb_stl_packet_framer;
  localparam int unsigned PB    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 50;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       timeout_drop;
  logic [4:0] debug_byte_count;
  logic [1:0] debug_state;
`ifdef STL_FRAMER_STATS_EN
  logic [1:0] stat_rx_pkts, stat_tx_pkts, stat_drops;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  stl_packet_framer_if #(.PACKET_BYTES(PB)) bus ();

  stl_packet_framer #(
    .PACKET_BYTES   (PB),
    .RSP_DEPTH      (DEPTH),
    .TIMEOUT_CYCLES (TO)
`ifdef STL_FRAMER_STATS_EN
    ,
    .STAT_W         (2)
`endif
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .link             (bus),
    .timeout_drop     (timeout_drop),
    .debug_byte_count (debug_byte_count),
    .debug_state      (debug_state)
`ifdef STL_FRAMER_STATS_EN
    ,
    .stat_rx_pkts     (stat_rx_pkts),
    .stat_tx_pkts     (stat_tx_pkts),
    .stat_drops       (stat_drops)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one byte and wait for it to be taken; returns on the falling edge after the accept
  task automatic send_byte(input logic [7:0] b);
    bit hs;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    do begin
      hs = bus.in_ready;
      @(negedge clk);
      n++;
    end while (!hs && n < 200);
    if (!hs) check("in_accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic send_pkt(input logic [7:0] base);
    for (int k = 0; k < int'(PB); k++) send_byte(8'(int'(base) + k));
    bus.in_valid = 1'b0;
  endtask

  task automatic push_pkt(input logic [127:0] p);
    bit hs;
    int n;
    n = 0;
    bus.rsp_pkt_valid = 1'b1;
    bus.rsp_pkt_data  = p;
    do begin
      hs = bus.rsp_pkt_ready;
      @(negedge clk);
      n++;
    end while (!hs && n < 2000);
    bus.rsp_pkt_valid = 1'b0;
    if (!hs) check("rsp_push_timeout", 128'd0, 128'd1);
  endtask

  function automatic logic [127:0] mk_pkt(input int base);
    logic [127:0] p;
    for (int k = 0; k < int'(PB); k++) p[8*k +: 8] = 8'(base + k);
    return p;
  endfunction

  initial begin
    int first;
    int idx;
    int gaps;
    reset_n           = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_data       = 8'h00;
    bus.pkt_ready     = 1'b0;
    bus.rsp_pkt_valid = 1'b0;
    bus.rsp_pkt_data  = '0;
    bus.out_ready     = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_pkt_valid", bus.pkt_valid, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_rsp_ready", bus.rsp_pkt_ready, 0);
    check("rst_state", debug_state, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_rsp_ready", bus.rsp_pkt_ready, 1);

    // 1: simple packet with pkt_ready held high
    bus.pkt_ready = 1'b1;
    send_pkt(8'h00);
    check("t1_pkt_valid", bus.pkt_valid, 1);
    check("t1_pkt_data", bus.pkt_data, 128'h0F0E0D0C0B0A09080706050403020100);
    check("t1_state_hold", debug_state, 2);
    check("t1_count_hold", debug_byte_count, 16);
    check("t1_in_ready_hold", bus.in_ready, 0);
    @(negedge clk);
    check("t1_pkt_valid_clr", bus.pkt_valid, 0);
    check("t1_state_idle", debug_state, 0);
    check("t1_count_clr", debug_byte_count, 0);
    check("t1_in_ready_back", bus.in_ready, 1);

    // 2: back-pressure on the packet side blocks the next byte
    bus.pkt_ready = 1'b0;
    send_pkt(8'h10);
    check("t2_pkt_valid", bus.pkt_valid, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    for (int c = 0; c < 20; c++) begin
      check("t2_in_ready_low", bus.in_ready, 0);
      check("t2_pkt_stable", bus.pkt_data, 128'h1F1E1D1C1B1A19181716151413121110);
      @(negedge clk);
    end
    bus.pkt_ready = 1'b1;
    send_byte(8'hAA);
    bus.pkt_ready = 1'b0;
    check("t2_pkt_valid_clr", bus.pkt_valid, 0);
    check("t2_count_after_aa", debug_byte_count, 1);
    check("t2_state_collect", debug_state, 1);
    for (int k = 1; k < int'(PB); k++) send_byte(8'(8'hAA + k));
    bus.in_valid = 1'b0;
    check("t2_aa_pkt", bus.pkt_data, 128'hB9B8B7B6B5B4B3B2B1B0AFAEADACABAA);
    bus.pkt_ready = 1'b1;
    @(negedge clk);
    check("t2_aa_pkt_done", bus.pkt_valid, 0);

    // 3: inter-byte timeout drops a partial packet after exactly 50 idle cycles
    for (int k = 1; k <= 5; k++) send_byte(8'(k));
    bus.in_valid = 1'b0;
    check("t3_count5", debug_byte_count, 5);
    first = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (timeout_drop) begin
        first = k;
        break;
      end
    end
    check("t3_drop_latency", first, 50);
    check("t3_count_clr", debug_byte_count, 0);
    check("t3_state_idle", debug_state, 0);
    @(negedge clk);
    check("t3_drop_pulse", timeout_drop, 0);
    send_pkt(8'h30);
    check("t3_clean_pkt", bus.pkt_data, 128'h3F3E3D3C3B3A39383736353433323130);
    @(negedge clk);

    // 4: fill the FIFO (one entry sits in the serializer) and drain in order
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_pkt(mk_pkt(i * 16));
    check("t4_full", bus.rsp_pkt_ready, 0);
    bus.rsp_pkt_valid = 1'b1;
    bus.rsp_pkt_data  = mk_pkt(8'hE0);
    repeat (5) @(negedge clk);
    check("t4_still_full", bus.rsp_pkt_ready, 0);
    check("t4_head_byte", bus.out_data, 8'h10);
    bus.rsp_pkt_valid = 1'b0;
    idx  = 0;
    gaps = 0;
    for (int c = 0; c < 400 && idx < 80; c++) begin
      bus.out_ready = 1'b1;
      if (bus.out_valid) begin
        check("t4_byte", bus.out_data, 8'(idx + 16));
        idx++;
      end else if (idx > 0) begin
        gaps++;
      end
      @(negedge clk);
    end
    check("t4_byte_count", idx, 80);
    check("t4_bubbles", gaps, 4);

    // 5: random back-pressure with concurrent pushes while the FIFO is full
    bus.out_ready = 1'b0;
    fork
      begin
        logic [127:0] p;
        for (int i = 0; i < 8; i++) begin
          for (int w = 0; w < 4; w++) p[32*w +: 32] = $urandom;
          push_pkt(p);
          for (int k = 0; k < int'(PB); k++) sb.push_back(p[8*k +: 8]);
        end
      end
      begin
        int rcv;
        rcv = 0;
        for (int c = 0; c < 6000 && rcv < 128; c++) begin
          bus.out_ready = (c < 60) ? 1'b0 : 1'($urandom_range(0, 1));
          if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) check("t5_extra_byte", 128'd1, 128'd0);
            else check("t5_byte", bus.out_data, sb.pop_front());
            rcv++;
          end
          @(negedge clk);
        end
        check("t5_byte_count", rcv, 128);
      end
    join
    check("t5_sb_empty", sb.size(), 0);
    repeat (4) @(negedge clk);
    check("t5_out_idle", bus.out_valid, 0);
    check("t5_rsp_ready", bus.rsp_pkt_ready, 1);

`ifdef STL_FRAMER_STATS_EN
    // 6: counters saturate at 3 with STAT_W=2
    for (int j = 0; j < 3; j++) begin
      send_byte(8'h55);
      bus.in_valid = 1'b0;
      repeat (60) @(negedge clk);
    end
    check("t6_stat_rx", stat_rx_pkts, 3);
    check("t6_stat_tx", stat_tx_pkts, 3);
    check("t6_stat_drops", stat_drops, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
